// File: rtl/bram_fifo_loader.sv
// Streams a contiguous block of BRAM words into a FIFO, one word per cycle when the FIFO
// has room, stalling on fifo_full without losing, duplicating or reordering words.
module bram_fifo_loader #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 10
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic [ADDR_WIDTH-1:0] base_addr,
    input  logic [ADDR_WIDTH:0]   length,
    output logic                  busy,
    output logic                  done,
    output logic                  bram_en,
    output logic [ADDR_WIDTH-1:0] bram_addr,
    input  logic [DATA_WIDTH-1:0] bram_dout,
    output logic                  fifo_write_enable,
    output logic [DATA_WIDTH-1:0] fifo_data_in,
    input  logic                  fifo_full
);

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    localparam logic [ADDR_WIDTH-1:0] ADDR_ONE = ADDR_WIDTH'(1);
    localparam logic [ADDR_WIDTH:0]   CNT_ONE  = (ADDR_WIDTH + 1)'(1);

    state_t                  state_q, state_d;
    logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
    logic [ADDR_WIDTH:0]     issue_left_q, issue_left_d;
    logic [ADDR_WIDTH:0]     write_left_q, write_left_d;
    logic                    inflight_q, inflight_d;
    logic                    hold_vld_q, hold_vld_d;
    logic                    done_q, done_d;
    logic [DATA_WIDTH-1:0]   hold_q;

    logic                    rd_issue;
    logic                    wr_fire;
    logic                    hold_capture;
    logic [DATA_WIDTH-1:0]   wr_data;

    always_comb begin
        state_d      = state_q;
        addr_d       = addr_q;
        issue_left_d = issue_left_q;
        write_left_d = write_left_q;
        inflight_d   = 1'b0;
        hold_vld_d   = hold_vld_q;
        done_d       = 1'b0;
        rd_issue     = 1'b0;
        wr_fire      = 1'b0;
        hold_capture = 1'b0;
        wr_data      = bram_dout;

        case (state_q)
            IDLE: begin
                if (start) begin
                    if (length != '0) begin
                        state_d      = RUN;
                        addr_d       = base_addr;
                        issue_left_d = length;
                        write_left_d = length;
                    end else begin
                        done_d = 1'b1;
                    end
                end
            end

            RUN: begin
                // A pending hold word blocks new reads so at most one word is ever parked.
                rd_issue = (issue_left_q != '0) && !hold_vld_q && !fifo_full;

                if (hold_vld_q) begin
                    if (!fifo_full) begin
                        wr_fire    = 1'b1;
                        wr_data    = hold_q;
                        hold_vld_d = 1'b0;
                    end
                end else if (inflight_q) begin
                    if (!fifo_full) begin
                        wr_fire = 1'b1;
                    end else begin
                        hold_capture = 1'b1;
                        hold_vld_d   = 1'b1;
                    end
                end

                inflight_d = rd_issue;
                if (rd_issue) begin
                    addr_d       = addr_q + ADDR_ONE;
                    issue_left_d = issue_left_q - CNT_ONE;
                end

                if (wr_fire) begin
                    write_left_d = write_left_q - CNT_ONE;
                    if (write_left_q == CNT_ONE) begin
                        state_d = IDLE;
                        done_d  = 1'b1;
                    end
                end
            end

            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q      <= IDLE;
            addr_q       <= '0;
            issue_left_q <= '0;
            write_left_q <= '0;
            inflight_q   <= 1'b0;
            hold_vld_q   <= 1'b0;
            done_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            addr_q       <= addr_d;
            issue_left_q <= issue_left_d;
            write_left_q <= write_left_d;
            inflight_q   <= inflight_d;
            hold_vld_q   <= hold_vld_d;
            done_q       <= done_d;
        end
    end

    // Hold data needs no reset: hold_vld_q alone decides whether it is meaningful.
    always_ff @(posedge clk) begin
        if (hold_capture) begin
            hold_q <= bram_dout;
        end
    end

    assign busy              = (state_q == RUN);
    assign done              = done_q;
    assign bram_en           = rd_issue;
    assign bram_addr         = addr_q;
    assign fifo_write_enable = wr_fire;
    assign fifo_data_in      = wr_fire ? wr_data : '0;

endmodule

// File: tb/tb_bram_fifo_loader.sv
// Scoreboard bench for bram_fifo_loader: stimulus queues expected reads and FIFO words,
// a negedge monitor pops and compares whenever the DUT reads BRAM or writes the FIFO.
module tb_bram_fifo_loader;

    localparam int DW = 32;
    localparam int AW = 10;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          start;
    logic [AW-1:0] base_addr;
    logic [AW:0]   length;
    logic          busy, done, bram_en;
    logic [AW-1:0] bram_addr;
    logic [DW-1:0] bram_dout = '0;
    logic          fifo_write_enable;
    logic [DW-1:0] fifo_data_in;
    logic          fifo_full;

    int errors = 0;
    int checks = 0;
    int cyc = 0;
    int n_rd = 0, n_wr = 0, n_done = 0, done_cyc = -1;
    int t0, rd0, wr0, d0;
    int wr_cycs[$];
    longint exp_addr_q[$];
    longint exp_data_q[$];

    bram_fifo_loader #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
        .clk(clk), .reset(rst_n), .start(start), .base_addr(base_addr), .length(length),
        .busy(busy), .done(done), .bram_en(bram_en), .bram_addr(bram_addr),
        .bram_dout(bram_dout), .fifo_write_enable(fifo_write_enable),
        .fifo_data_in(fifo_data_in), .fifo_full(fifo_full)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    function automatic logic [DW-1:0] word_at(input logic [AW-1:0] a);
        return {8'hA5, 4'h0, a, a};
    endfunction

    // BRAM model: registered read, data valid the cycle after bram_en.
    always @(posedge clk) if (bram_en) bram_dout <= word_at(bram_addr);

    task automatic chk(input string name, input longint act, input longint exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    always @(negedge clk) begin
        if (rst_n) begin
            if (bram_en) begin
                n_rd++;
                if (exp_addr_q.size() == 0) chk("rd_unexpected", 1, 0);
                else chk("rd_addr", longint'(bram_addr), exp_addr_q.pop_front());
            end
            if (fifo_write_enable) begin
                n_wr++;
                wr_cycs.push_back(cyc);
                chk("wr_while_full", longint'(fifo_full), 0);
                if (exp_data_q.size() == 0) chk("wr_unexpected", 1, 0);
                else chk("wr_data", longint'(fifo_data_in), exp_data_q.pop_front());
            end
            if (done) begin
                n_done++;
                done_cyc = cyc;
                chk("busy_at_done", longint'(busy), 0);
            end
        end
    end

    // Caller positions time just after a clock edge; the next rising edge accepts start.
    task automatic issue_start(input logic [AW-1:0] b, input int len);
        logic [AW-1:0] a;
        rd0 = n_rd; wr0 = n_wr; d0 = n_done;
        wr_cycs.delete();
        a = b;
        for (int i = 0; i < len; i++) begin
            exp_addr_q.push_back(longint'(a));
            exp_data_q.push_back(longint'(word_at(a)));
            a = a + 1'b1;
        end
        base_addr = b;
        length    = (AW + 1)'(len);
        start     = 1'b1;
        t0        = cyc;
        @(posedge clk); #1;
        start     = 1'b0;
    endtask

    task automatic wait_done(input string name);
        int k = 0;
        while (n_done == d0 && k < 300) begin
            @(posedge clk);
            k++;
        end
        if (k >= 300) chk({name, "_timeout"}, 0, 1);
        @(posedge clk); #1;
        chk({name, "_exp_empty"}, longint'(exp_addr_q.size() + exp_data_q.size()), 0);
    endtask

    initial begin
        rst_n = 1'b0; start = 1'b0; fifo_full = 1'b0;
        base_addr = '0; length = '0;
        #3;
        chk("rst_busy", longint'(busy), 0);
        chk("rst_done", longint'(done), 0);
        chk("rst_bram_en", longint'(bram_en), 0);
        chk("rst_fwe", longint'(fifo_write_enable), 0);
        chk("rst_bram_addr", longint'(bram_addr), 0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        @(posedge clk); #1;

        // Basic transfer at full rate.
        issue_start(10'h010, 4);
        wait_done("basic");
        chk("basic_nrd", n_rd - rd0, 4);
        chk("basic_nwr", n_wr - wr0, 4);
        chk("basic_first_wr", wr_cycs.size() > 0 ? wr_cycs[0] : -1, t0 + 2);
        chk("basic_last_wr", wr_cycs.size() > 3 ? wr_cycs[3] : -1, t0 + 5);
        chk("basic_done_cyc", done_cyc, t0 + 6);
        chk("basic_ndone", n_done - d0, 1);

        // Address wrap at the top of the BRAM.
        @(posedge clk); #1;
        issue_start(10'h3FE, 4);
        wait_done("wrap");
        chk("wrap_nwr", n_wr - wr0, 4);
        chk("wrap_done_cyc", done_cyc, t0 + 6);

        // Zero length: immediate done, no traffic.
        @(posedge clk); #1;
        issue_start(10'h055, 0);
        chk("zero_done_pulse", longint'(done), 1);
        chk("zero_busy", longint'(busy), 0);
        repeat (3) @(posedge clk); #1;
        chk("zero_ndone", n_done - d0, 1);
        chk("zero_done_cyc", done_cyc, t0 + 1);
        chk("zero_traffic", (n_rd - rd0) + (n_wr - wr0), 0);

        // Backpressure: full raised the cycle after the first read, held five cycles.
        @(posedge clk); #1;
        issue_start(10'h020, 3);
        @(posedge clk); #1 fifo_full = 1'b1;
        repeat (5) @(posedge clk);
        #1 fifo_full = 1'b0;
        wait_done("bp");
        chk("bp_nwr", n_wr - wr0, 3);
        chk("bp_nrd", n_rd - rd0, 3);
        chk("bp_first_wr", wr_cycs.size() > 0 ? wr_cycs[0] : -1, t0 + 7);
        chk("bp_done_cyc", done_cyc, t0 + 11);

        // Second start during RUN is ignored.
        @(posedge clk); #1;
        issue_start(10'h100, 5);
        @(posedge clk); #1;
        base_addr = 10'h200; length = 11'd2; start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        wait_done("restart");
        chk("restart_nwr", n_wr - wr0, 5);
        chk("restart_ndone", n_done - d0, 1);
        chk("restart_done_cyc", done_cyc, t0 + 7);

        // Reset mid-transfer with a read in flight, then restart on the first edge.
        @(posedge clk); #1;
        issue_start(10'h040, 6);
        @(posedge clk); #2;
        rst_n = 1'b0;
        #1;
        exp_addr_q.delete();
        exp_data_q.delete();
        chk("abort_busy", longint'(busy), 0);
        chk("abort_bram_en", longint'(bram_en), 0);
        chk("abort_fwe", longint'(fifo_write_enable), 0);
        chk("abort_bram_addr", longint'(bram_addr), 0);
        chk("abort_done", longint'(done), 0);
        @(posedge clk);
        @(negedge clk); #1;
        chk("abort_no_done", n_done - d0, 0);
        rst_n = 1'b1;
        issue_start(10'h080, 2);
        wait_done("post_rst");
        chk("post_rst_nwr", n_wr - wr0, 2);
        chk("post_rst_first_wr", wr_cycs.size() > 0 ? wr_cycs[0] : -1, t0 + 2);
        chk("post_rst_done_cyc", done_cyc, t0 + 4);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/bram_fifo_loader.md
BRAM_FIFO_LOADER -- requirements
Module: bram_fifo_loader

Interface
REQ-001 Parameter DATA_WIDTH, default 32, word width of the BRAM read port and the FIFO write port.
REQ-002 Parameter ADDR_WIDTH, default 10, BRAM word-address width.
REQ-003 clk  input  1  single clock; all logic on its rising edge.
REQ-004 reset  input  1  asynchronous, active-low reset (0 = reset asserted).
REQ-005 start  input  1  one-cycle request to begin a transfer; sampled only in IDLE.
REQ-006 base_addr  input  ADDR_WIDTH  first BRAM word address; captured on accepted start.
REQ-007 length  input  ADDR_WIDTH+1  number of words to transfer; captured on accepted start.
REQ-008 busy  output  1  high while in RUN.
REQ-009 done  output  1  one-cycle pulse when a transfer completes.
REQ-010 bram_en  output  1  BRAM read enable.
REQ-011 bram_addr  output  ADDR_WIDTH  BRAM read address.
REQ-012 bram_dout  input  DATA_WIDTH  BRAM read data, valid exactly 1 cycle after the bram_en cycle.
REQ-013 fifo_write_enable  output  1  write strobe to the output FIFO.
REQ-014 fifo_data_in  output  DATA_WIDTH  word written to the output FIFO.
REQ-015 fifo_full  input  1  FIFO full flag; combinational from FIFO state, FIFO drops writes while high.

Function
REQ-016 States: IDLE, RUN; IDLE -> RUN on start with length != 0; RUN -> IDLE on the cycle the last word is written to the FIFO.
REQ-017 start with length == 0 in IDLE: no BRAM reads, no FIFO writes, done pulses the next cycle, state stays IDLE.
REQ-018 start while in RUN is ignored; base_addr/length changes in RUN have no effect.
REQ-019 Counters: read address (ADDR_WIDTH), words-left-to-issue and words-left-to-write (ADDR_WIDTH+1 each); address wraps modulo 2^ADDR_WIDTH.
REQ-020 A read is issued (bram_en=1, bram_addr=current read address) in a cycle iff RUN, words-left-to-issue > 0, hold register empty, and fifo_full == 0.
REQ-021 Each issued read increments the read address and decrements words-left-to-issue; at most one read is in flight.
REQ-022 Returning data (cycle after issue): if fifo_full == 0 it is written directly (fifo_write_enable=1, fifo_data_in=bram_dout); otherwise it is captured in a one-word hold register.
REQ-023 A non-empty hold register is written to the FIFO in the first cycle fifo_full == 0, then marked empty; no new read is issued in that cycle.
REQ-024 fifo_write_enable is never asserted while fifo_full == 1; no word is lost or duplicated; FIFO receives words in ascending address order.
REQ-025 Throughput with fifo_full low throughout: one word per cycle; first FIFO write 2 cycles after the accepted start cycle.
REQ-026 done pulses the cycle after the final FIFO write; busy deasserts the same cycle done pulses.
REQ-027 bram_en, fifo_write_enable, done are 0 in all cycles not covered above; fifo_data_in is don't-care when fifo_write_enable == 0.

Reset
REQ-028 reset low asynchronously forces IDLE, busy=0, done=0, bram_en=0, fifo_write_enable=0, bram_addr=0, hold register empty, all counters 0.
REQ-029 reset asserted mid-transfer abandons the transfer: in-flight BRAM data is discarded, no done pulse is produced.
REQ-030 After reset deasserts, the block accepts start on the first clock edge.

Verification
REQ-031 base_addr=0x010, length=4, fifo_full=0 -> bram_addr 0x010..0x013 on consecutive cycles, 4 FIFO writes of BRAM[0x010..0x013] in order, done one cycle after the 4th write.
REQ-032 length=3, fifo_full forced high 1 cycle after the first read for 5 cycles -> first word held, no write while full, then words delivered in order, exactly 3 writes total.
REQ-033 base_addr=0x3FE, length=4 (ADDR_WIDTH=10) -> addresses 0x3FE, 0x3FF, 0x000, 0x001.
REQ-034 start with length=0 -> no bram_en, no FIFO write, done pulses next cycle, busy stays 0.
REQ-035 start pulsed again mid-transfer with different base_addr -> ignored; original transfer completes unchanged.
REQ-036 reset pulsed low during RUN with a read in flight -> all outputs 0 immediately, no FIFO write of the in-flight word, no done; a new start afterward runs normally.
